// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor with a 64-bit machine timer and a software interrupt bit.
// Responds to the CPU data bus with one-cycle latency and drives xint_mtip / xint_msip.
// Optional build macro CLINT_PRESCALER_EN: when defined, mtime advances once every TICK_DIV cycles;
// when undefined, mtime advances every cycle.
module clint_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wsel,
    input  logic        mem_valid,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_error,
    output logic        xint_mtip,
    output logic        xint_msip
);

    localparam logic [15:0] OFF_MSIP    = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
    localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;

    typedef enum logic {IDLE, ACK} state_t;

    // Reject an unusable prescale ratio at elaboration
    if (TICK_DIV == 0 || TICK_DIV > 65535) begin : g_bad_tick_div
        $error("clint_timer: TICK_DIV must be within 1..65535");
    end

    state_t      state_q;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic [31:0] rdata_q;
    logic        ready_q, error_q, mtip_q, xmsip_q;

    logic        tick;
    logic        req;
    logic        is_wr;
    logic        bad;
    logic [15:0] offset;
    logic [31:0] rdata_d;

    // Replace the byte lanes selected by sel_v
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel_v);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel_v[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

`ifdef CLINT_PRESCALER_EN
    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);
    logic [15:0] div_q;

    assign tick = (div_q == DIV_LAST);

    // Free-running prescaler; mtime writes do not disturb it
    always_ff @(posedge clk) begin
        if (rst)       div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + 16'd1;
    end
`else
    assign tick = 1'b1;
`endif

    // Address decode and read mux for the request presented this cycle
    always_comb begin
        offset  = mem_address[15:0];
        req     = mem_valid && (state_q == IDLE) && (mem_address[31:16] == BASE_ADDR[31:16]);
        is_wr   = (mem_wsel != 4'b0000);
        bad     = (mem_address[1:0] != 2'b00);
        rdata_d = '0;
        case (offset)
            OFF_MSIP:    rdata_d = {31'd0, msip_q};
            OFF_CMP_LO:  rdata_d = mtimecmp_q[31:0];
            OFF_CMP_HI:  rdata_d = mtimecmp_q[63:32];
            OFF_TIME_LO: rdata_d = mtime_q[31:0];
            OFF_TIME_HI: rdata_d = mtime_q[63:32];
            default:     bad = 1'b1;
        endcase
        if (bad || is_wr) rdata_d = '0;
    end

    // Register next-state: a bus write to mtime overrides the tick, the other half holds
    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (req && is_wr && !bad) begin
            case (offset)
                OFF_MSIP:    if (mem_wsel[0]) msip_d = mem_wdata[0];
                OFF_CMP_LO:  mtimecmp_d[31:0]  = merge_lanes(mtimecmp_q[31:0], mem_wdata, mem_wsel);
                OFF_CMP_HI:  mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], mem_wdata, mem_wsel);
                OFF_TIME_LO: mtime_d = {mtime_q[63:32], merge_lanes(mtime_q[31:0], mem_wdata, mem_wsel)};
                OFF_TIME_HI: mtime_d = {merge_lanes(mtime_q[63:32], mem_wdata, mem_wsel), mtime_q[31:0]};
                default:     ;
            endcase
        end
    end

    // Bus FSM, timer registers and interrupt outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            mtip_q     <= 1'b0;
            xmsip_q    <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= (mtime_d >= mtimecmp_d);
            xmsip_q    <= msip_q;
            if (state_q == ACK) begin
                state_q <= IDLE;
                ready_q <= 1'b0;
                error_q <= 1'b0;
                rdata_q <= '0;
            end else if (req) begin
                state_q <= ACK;
                ready_q <= 1'b1;
                error_q <= bad;
                rdata_q <= rdata_d;
            end
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_error = error_q;
    assign xint_mtip = mtip_q;
    assign xint_msip = xmsip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: directed scenarios plus random bus traffic, with responses checked
// by a decoupled scoreboard monitor against an arithmetic model of the timer.
`timescale 1ns/1ps
module tb_clint_timer;

`ifdef CLINT_PRESCALER_EN
    localparam int unsigned DIV = 4;
`else
    localparam int unsigned DIV = 1;
`endif
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_address = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wsel = '0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_error;
    logic        xint_mtip;
    logic        xint_msip;

    always #5 clk = ~clk;

    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_wsel    (mem_wsel),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .mem_error   (mem_error),
        .xint_mtip   (xint_mtip),
        .xint_msip   (xint_msip)
    );

    // Edge index since reset release: a request driven while cyc==n is sampled on edge n
    int unsigned cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk_rd;
        int unsigned cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   chk_en = 1'b0;

    // Timer model: mtime = base value plus the ticks elapsed since the edge after the last write
    logic [63:0] m_base;
    int unsigned m_base_e;
    logic [63:0] m_cmp;
    bit          m_msip, m_msip_prev;
    int          m_msip_w;

    task automatic model_reset();
        m_base = '0; m_base_e = 0; m_cmp = '1;
        m_msip = 1'b0; m_msip_prev = 1'b0; m_msip_w = -100;
    endtask

    function automatic logic [63:0] mtime_at(input int unsigned e);
        return m_base + 64'(e / DIV - m_base_e / DIV);
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_v & ~m) | (new_v & m);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_irq();
        int k;
        bit exp_ms;
        if (!chk_en) return;
        k = int'(cyc);
        check("xint_mtip", {63'd0, xint_mtip}, {63'd0, mtime_at(cyc) >= m_cmp});
        exp_ms = (k - 2 >= m_msip_w) ? m_msip : m_msip_prev;
        check("xint_msip", {63'd0, xint_msip}, {63'd0, exp_ms});
    endtask

    task automatic tick();
        @(negedge clk);
        check_irq();
    endtask

    // Issue one in-window access (called at a negedge); keep=1 leaves valid high for back-to-back
    task automatic bus_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input bit keep);
        exp_t        e;
        logic [15:0] off;
        logic [63:0] t;
        bit          err;
        off = a[15:0];
        err = (a[1:0] != 2'b00) ||
              !(off inside {16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC});
        e.cyc = cyc + 1; e.err = err; e.rdata = '0; e.chk_rd = err || (ws == 4'b0000);
        if (!err) begin
            t = mtime_at(cyc);
            if (ws == 4'b0000) begin
                case (off)
                    16'h0000: e.rdata = {31'd0, m_msip};
                    16'h4000: e.rdata = m_cmp[31:0];
                    16'h4004: e.rdata = m_cmp[63:32];
                    16'hBFF8: e.rdata = t[31:0];
                    16'hBFFC: e.rdata = t[63:32];
                    default:  ;
                endcase
            end else begin
                case (off)
                    16'h0000: if (ws[0]) begin
                        m_msip_prev = m_msip; m_msip = wd[0]; m_msip_w = int'(cyc);
                    end
                    16'h4000: m_cmp[31:0]  = lanes(m_cmp[31:0], wd, ws);
                    16'h4004: m_cmp[63:32] = lanes(m_cmp[63:32], wd, ws);
                    16'hBFF8: begin t[31:0]  = lanes(t[31:0], wd, ws);  m_base = t; m_base_e = cyc + 1; end
                    16'hBFFC: begin t[63:32] = lanes(t[63:32], wd, ws); m_base = t; m_base_e = cyc + 1; end
                    default:  ;
                endcase
            end
        end
        q.push_back(e);
        mem_address = a; mem_wdata = wd; mem_wsel = ws; mem_valid = 1'b1;
        tick();
        tick();
        if (!keep) begin mem_valid = 1'b0; mem_wsel = '0; end
    endtask

    // Request for another slave: must never be acknowledged
    task automatic foreign_req(input logic [31:0] a);
        mem_address = a; mem_wsel = '0; mem_valid = 1'b1;
        repeat (5) begin
            tick();
            check("foreign_no_ready", {63'd0, mem_ready}, 64'd0);
        end
        mem_valid = 1'b0;
    endtask

    // Scoreboard monitor: pops one expectation per observed response
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mem_ready === 1'b1) begin
                    if (q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_ready: actual=1 required=0 (cyc %0d)", cyc);
                    end else begin
                        e = q.pop_front();
                        check("ready_latency", 64'(cyc), 64'(e.cyc));
                        check("mem_error", {63'd0, mem_error}, {63'd0, e.err});
                        if (e.chk_rd) check("mem_rdata", {32'd0, mem_rdata}, {32'd0, e.rdata});
                    end
                end else begin
                    check("rdata_idle", {32'd0, mem_rdata}, 64'd0);
                    if (q.size() != 0 && q[0].cyc <= cyc) begin
                        e = q.pop_front();
                        n_cmp++; n_bad++;
                        $display("FAIL missing_ready: actual=0 required=1 (cyc %0d)", cyc);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish (cyc %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] a, wd;
        logic [3:0]  ws;
        bit          keep;
        int          sel;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1; chk_en = 1'b1;
        check("rst_rdata", {32'd0, mem_rdata}, 64'd0);
        check("rst_ready", {63'd0, mem_ready}, 64'd0);
        check("rst_error", {63'd0, mem_error}, 64'd0);
        check("rst_mtip",  {63'd0, xint_mtip}, 64'd0);
        check("rst_msip",  {63'd0, xint_msip}, 64'd0);

        while (cyc < 10) tick();
        bus_req(BASE | 32'hBFF8, '0, 4'h0, 1'b0);
        bus_req(BASE | 32'h4004, '0, 4'h0, 1'b0);
        bus_req(BASE | 32'hBFF8, '0, 4'h0, 1'b1);
        bus_req(BASE | 32'hBFFC, '0, 4'h0, 1'b1);
        bus_req(BASE | 32'h4000, '0, 4'h0, 1'b0);
        while (cyc < 40) tick();
        bus_req(BASE | 32'hBFF8, '0, 4'h0, 1'b0);

        // Timer interrupt rise and clear
        bus_req(BASE | 32'h4004, 32'd0, 4'hF, 1'b0);
        bus_req(BASE | 32'h4000, 32'd200, 4'hF, 1'b0);
        for (int i = 0; i < 3000 && mtime_at(cyc) < 64'd210; i++) tick();
        check("mtip_high", {63'd0, xint_mtip}, 64'd1);
        bus_req(BASE | 32'h4000, 32'hFFFF_FFFF, 4'hF, 1'b0);
        check("mtip_cleared", {63'd0, xint_mtip}, 64'd0);

        // Software interrupt, then a write that skips lane 0
        bus_req(BASE | 32'h0000, 32'd1, 4'b0001, 1'b0);
        tick();
        check("msip_set", {63'd0, xint_msip}, 64'd1);
        bus_req(BASE | 32'h0000, 32'd0, 4'b1110, 1'b0);
        bus_req(BASE | 32'h0000, '0, 4'h0, 1'b0);

        // Faults
        bus_req(BASE | 32'h0008, '0, 4'h0, 1'b0);
        bus_req(BASE | 32'h4002, '0, 4'h0, 1'b0);
        foreign_req(32'h8000_0000);

        // Wrap and write/increment collision
        bus_req(BASE | 32'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b1);
        bus_req(BASE | 32'hBFF8, 32'hFFFF_FFFE, 4'hF, 1'b0);
        repeat (2 * DIV + 2) tick();
        bus_req(BASE | 32'hBFF8, '0, 4'h0, 1'b0);
        bus_req(BASE | 32'hBFFC, '0, 4'h0, 1'b0);
        bus_req(BASE | 32'hBFF8, 32'h0000_1234, 4'b0011, 1'b0);
        bus_req(BASE | 32'hBFF8, '0, 4'h0, 1'b0);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            a = BASE;
            case (sel)
                0:       a[15:0] = 16'h0000;
                1, 8:    a[15:0] = 16'h4000;
                2:       a[15:0] = 16'h4004;
                3, 9:    a[15:0] = 16'hBFF8;
                4:       a[15:0] = 16'hBFFC;
                5:       a[15:0] = 16'($urandom) & 16'hFFFC;
                6:       a[15:0] = 16'hBFF8 | 16'($urandom_range(1, 3));
                default: a = {16'h8000 | 16'($urandom_range(0, 32767)), 16'($urandom)};
            endcase
            wd = $urandom;
            ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            keep = ($urandom_range(0, 3) == 0) && (i != 199);
            if (sel == 7) foreign_req(a);
            else          bus_req(a, wd, ws, keep);
            if (!keep) repeat ($urandom_range(0, 2)) tick();
        end
        mem_valid = 1'b0; mem_wsel = '0;
        tick();

        // Reset arriving together with a request drops it and clears all state
        bus_req(BASE | 32'h0000, 32'd1, 4'b0001, 1'b0);
        bus_req(BASE | 32'h4004, 32'd0, 4'hF, 1'b0);
        bus_req(BASE | 32'h4000, 32'd0, 4'hF, 1'b0);
        tick();
        chk_en = 1'b0;
        rst = 1'b1;
        mem_address = BASE | 32'hBFF8; mem_wdata = 32'h5555; mem_wsel = 4'hF; mem_valid = 1'b1;
        @(negedge clk);
        check("rst_drop_ready", {63'd0, mem_ready}, 64'd0);
        check("rst_mtip_clr",   {63'd0, xint_mtip}, 64'd0);
        rst = 1'b0; mem_valid = 1'b0; mem_wsel = '0;
        model_reset();
        chk_en = 1'b1;
        while (cyc < 5) tick();
        bus_req(BASE | 32'hBFF8, '0, 4'h0, 1'b0);
        bus_req(BASE | 32'h4004, '0, 4'h0, 1'b0);
        bus_req(BASE | 32'h0000, '0, 4'h0, 1'b0);
        repeat (3) tick();

        check("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
